// File: rtl/cmp_mon_pkg.sv
// Shared types and decode helper for the comparator result monitor.
// Pure declarations; no latency, no flow control.
package cmp_mon_pkg;

    typedef enum logic [1:0] {
        RES_NONE = 2'd0,
        RES_GT   = 2'd1,
        RES_EQ   = 2'd2,
        RES_LT   = 2'd3
    } cmp_res_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_TRACK = 2'd1,
        ST_ERR   = 2'd2
    } cmp_mon_state_t;

    // f = {f1, f2, f3}; priority GT > EQ > LT so malformed codes still decode
    function automatic cmp_res_t onehot_to_res(input logic [2:0] f);
        cmp_res_t r;
        if (f[2])      r = RES_GT;
        else if (f[1]) r = RES_EQ;
        else if (f[0]) r = RES_LT;
        else           r = RES_NONE;
        return r;
    endfunction

endpackage

// File: rtl/cmp_mon_sat_cnt.sv
// Saturating up-counter used for the per-result tallies.
// Latency 1: q updates on the edge where inc is sampled.
// No backpressure; holds at all-ones once saturated.
module cmp_mon_sat_cnt #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] q
);

    always_ff @(posedge clk) begin
        if (reset) begin
            q <= '0;
        end else if (clr) begin
            q <= '0;
        end else if (inc && (q != {W{1'b1}})) begin
            q <= q + W'(1);
        end
    end

endmodule

// File: rtl/cmp_result_monitor.sv
// Tallies comparator results, tracks run length and stability; CMP_MON_ONEHOT_CHECK_EN adds err/ERR.
// Latency 1: a sample accepted on edge k is visible on all outputs after edge k.
// No backpressure: every in_valid sample is consumed or dropped on its edge.
module cmp_result_monitor
    import cmp_mon_pkg::*;
#(
    parameter int CNT_W      = 8,
    parameter int RUN_W      = 4,
    parameter int STABLE_LEN = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             in_valid,
    input  logic             f1,
    input  logic             f2,
    input  logic             f3,
    output logic [CNT_W-1:0] gt_cnt,
    output logic [CNT_W-1:0] eq_cnt,
    output logic [CNT_W-1:0] lt_cnt,
    output logic [RUN_W-1:0] run_len,
    output logic [1:0]       last_res,
    output logic             stable,
    output logic             err
);

    localparam logic [RUN_W-1:0] STABLE_THR = RUN_W'(STABLE_LEN);
    localparam logic [RUN_W-1:0] RUN_MAX    = {RUN_W{1'b1}};

    logic [2:0]       f_vec;
    cmp_res_t         res;
    cmp_res_t         last_q;
    cmp_mon_state_t   state;
    logic             accept;
    logic [RUN_W-1:0] run_nxt;

    assign f_vec    = {f1, f2, f3};
    assign res      = onehot_to_res(f_vec);
    assign last_res = last_q;

    always_comb begin
        accept = 1'b0;
`ifdef CMP_MON_ONEHOT_CHECK_EN
        accept = in_valid && (state != ST_ERR) && $onehot(f_vec);
`else
        accept = in_valid && (res != RES_NONE);
`endif
        run_nxt = RUN_W'(1);
        if (res == last_q) begin
            run_nxt = (run_len == RUN_MAX) ? run_len : run_len + RUN_W'(1);
        end
    end

`ifdef CMP_MON_ONEHOT_CHECK_EN
    logic err_q;
    assign err = err_q;
`else
    assign err = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            run_len <= '0;
            last_q  <= RES_NONE;
            stable  <= 1'b0;
            state   <= ST_IDLE;
`ifdef CMP_MON_ONEHOT_CHECK_EN
            err_q   <= 1'b0;
`endif
        end else if (accept) begin
            run_len <= run_nxt;
            last_q  <= res;
            stable  <= (run_nxt >= STABLE_THR);
            state   <= ST_TRACK;
        end
`ifdef CMP_MON_ONEHOT_CHECK_EN
        // A malformed code locks the monitor until software clears it
        else if (in_valid && (state != ST_ERR)) begin
            state <= ST_ERR;
            err_q <= 1'b1;
        end
`endif
    end

    cmp_mon_sat_cnt #(.W(CNT_W)) u_gt_cnt (
        .clk   (clk),
        .reset (reset),
        .clr   (clear),
        .inc   (accept && (res == RES_GT)),
        .q     (gt_cnt)
    );

    cmp_mon_sat_cnt #(.W(CNT_W)) u_eq_cnt (
        .clk   (clk),
        .reset (reset),
        .clr   (clear),
        .inc   (accept && (res == RES_EQ)),
        .q     (eq_cnt)
    );

    cmp_mon_sat_cnt #(.W(CNT_W)) u_lt_cnt (
        .clk   (clk),
        .reset (reset),
        .clr   (clear),
        .inc   (accept && (res == RES_LT)),
        .q     (lt_cnt)
    );

endmodule

// File: tb/tb_cmp_result_monitor.sv
// Directed bench for cmp_result_monitor: vector table plus hand sequences for saturation,
// clear priority, illegal codes and a full two-bit comparator sweep.
module tb_cmp_result_monitor;
    import cmp_mon_pkg::*;

    logic clk = 1'b0;
    logic reset, clear, in_valid, f1, f2, f3;

    logic [7:0] gt_cnt, eq_cnt, lt_cnt;
    logic [3:0] run_len;
    logic [1:0] last_res;
    logic       stable, err;

    logic [1:0] s_gt_cnt, s_eq_cnt, s_lt_cnt;
    logic [3:0] s_run_len;
    logic [1:0] s_last_res;
    logic       s_stable, s_err;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    cmp_result_monitor dut (
        .clk(clk), .reset(reset), .clear(clear), .in_valid(in_valid),
        .f1(f1), .f2(f2), .f3(f3),
        .gt_cnt(gt_cnt), .eq_cnt(eq_cnt), .lt_cnt(lt_cnt),
        .run_len(run_len), .last_res(last_res), .stable(stable), .err(err)
    );

    // Narrow-counter instance sharing the same stimulus, for saturation checks
    cmp_result_monitor #(.CNT_W(2)) dut_s (
        .clk(clk), .reset(reset), .clear(clear), .in_valid(in_valid),
        .f1(f1), .f2(f2), .f3(f3),
        .gt_cnt(s_gt_cnt), .eq_cnt(s_eq_cnt), .lt_cnt(s_lt_cnt),
        .run_len(s_run_len), .last_res(s_last_res), .stable(s_stable), .err(s_err)
    );

    typedef struct {
        logic       clr;
        logic       vld;
        logic [2:0] f;
        logic [7:0] gt;
        logic [7:0] eq;
        logic [7:0] lt;
        logic [3:0] run;
        logic [1:0] last;
        logic       st;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input logic c, input logic v, input logic [2:0] f,
                                input int g, input int e, input int l,
                                input int r, input int la, input int s);
        vec_t x;
        x.clr = c; x.vld = v; x.f = f;
        x.gt = 8'(g); x.eq = 8'(e); x.lt = 8'(l);
        x.run = 4'(r); x.last = 2'(la); x.st = s[0];
        return x;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic chk_outs(input string tag, input int g, input int e, input int l,
                            input int r, input int la, input int s, input int er);
        chk({tag, ".gt_cnt"},   32'(gt_cnt),   32'(g));
        chk({tag, ".eq_cnt"},   32'(eq_cnt),   32'(e));
        chk({tag, ".lt_cnt"},   32'(lt_cnt),   32'(l));
        chk({tag, ".run_len"},  32'(run_len),  32'(r));
        chk({tag, ".last_res"}, 32'(last_res), 32'(la));
        chk({tag, ".stable"},   32'(stable),   32'(s));
        chk({tag, ".err"},      32'(err),      32'(er));
    endtask

    // Inputs change on the falling edge; outputs are sampled 1 time unit after the rising edge
    task automatic drive(input logic c, input logic v, input logic [2:0] f);
        @(negedge clk);
        clear = c; in_valid = v; {f1, f2, f3} = f;
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1; clear = 1'b0; in_valid = 1'b0; {f1, f2, f3} = 3'b000;
        repeat (2) @(posedge clk);
        #1;
        chk_outs("reset", 0, 0, 0, 0, 0, 0, 0);
        chk("reset.state", 32'(dut.state), 32'(ST_IDLE));
        @(negedge clk);
        reset = 1'b0;

        // four GT, stable from the third; clear; GT GT EQ LT LT with idle gaps; clear+valid
        tbl.push_back(mk(0, 1, 3'b100, 1, 0, 0, 1, 1, 0));
        tbl.push_back(mk(0, 1, 3'b100, 2, 0, 0, 2, 1, 0));
        tbl.push_back(mk(0, 1, 3'b100, 3, 0, 0, 3, 1, 1));
        tbl.push_back(mk(0, 1, 3'b100, 4, 0, 0, 4, 1, 1));
        tbl.push_back(mk(1, 0, 3'b000, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 1, 3'b100, 1, 0, 0, 1, 1, 0));
        tbl.push_back(mk(0, 0, 3'b100, 1, 0, 0, 1, 1, 0));
        tbl.push_back(mk(0, 1, 3'b100, 2, 0, 0, 2, 1, 0));
        tbl.push_back(mk(0, 1, 3'b010, 2, 1, 0, 1, 2, 0));
        tbl.push_back(mk(0, 0, 3'b001, 2, 1, 0, 1, 2, 0));
        tbl.push_back(mk(0, 1, 3'b001, 2, 1, 1, 1, 3, 0));
        tbl.push_back(mk(0, 1, 3'b001, 2, 1, 2, 2, 3, 0));
        tbl.push_back(mk(1, 1, 3'b100, 0, 0, 0, 0, 0, 0));

        foreach (tbl[i]) begin
            drive(tbl[i].clr, tbl[i].vld, tbl[i].f);
            chk_outs($sformatf("vec%0d", i), int'(tbl[i].gt), int'(tbl[i].eq), int'(tbl[i].lt),
                     int'(tbl[i].run), int'(tbl[i].last), int'(tbl[i].st), 0);
        end
        chk("clr_vld.state", 32'(dut.state), 32'(ST_IDLE));

        // reset outranks a simultaneous valid sample
        drive(0, 1, 3'b100);
        @(negedge clk);
        reset = 1'b1; in_valid = 1'b1; {f1, f2, f3} = 3'b010;
        @(posedge clk);
        #1;
        chk_outs("rst_vld", 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        reset = 1'b0;

        // counter saturation on the 2-bit instance
        drive(1, 0, 3'b000);
        for (int i = 0; i < 5; i++) drive(0, 1, 3'b010);
        chk("sat.s_eq_cnt",  32'(s_eq_cnt),  32'd3);
        chk("sat.s_run_len", 32'(s_run_len), 32'd5);
        chk("sat.s_stable",  32'(s_stable),  32'd1);
        chk("sat.eq_cnt",    32'(eq_cnt),    32'd5);

        // run_len saturation at 15
        drive(1, 0, 3'b000);
        for (int i = 0; i < 17; i++) drive(0, 1, 3'b100);
        chk_outs("runsat", 17, 0, 0, 15, 1, 1, 0);
        chk("runsat.s_gt_cnt", 32'(s_gt_cnt), 32'd3);

        drive(1, 0, 3'b000);
`ifdef CMP_MON_ONEHOT_CHECK_EN
        drive(0, 1, 3'b110);
        chk_outs("bad110", 0, 0, 0, 0, 0, 0, 1);
        chk("bad110.state", 32'(dut.state), 32'(ST_ERR));
        drive(0, 1, 3'b100);
        chk_outs("err_hold", 0, 0, 0, 0, 0, 0, 1);
        drive(1, 0, 3'b000);
        chk_outs("err_clr", 0, 0, 0, 0, 0, 0, 0);
        chk("err_clr.state", 32'(dut.state), 32'(ST_IDLE));
        drive(0, 1, 3'b100);
        drive(0, 1, 3'b000);
        chk_outs("bad000", 1, 0, 0, 1, 1, 0, 1);
        drive(0, 1, 3'b001);
        chk_outs("err_hold2", 1, 0, 0, 1, 1, 0, 1);
`else
        drive(0, 1, 3'b110);
        chk_outs("prio110", 1, 0, 0, 1, 1, 0, 0);
        drive(0, 1, 3'b000);
        chk_outs("none000", 1, 0, 0, 1, 1, 0, 0);
        drive(0, 1, 3'b011);
        chk_outs("prio011", 1, 1, 0, 1, 2, 0, 0);
        drive(0, 1, 3'b111);
        chk_outs("prio111", 2, 1, 0, 1, 1, 0, 0);
`endif

        // every {a,b} pair through a two-bit comparator model; ends GT(3,2) then EQ(3,3)
        drive(1, 0, 3'b000);
        for (int a = 0; a < 4; a++) begin
            for (int b = 0; b < 4; b++) begin
                drive(0, 1, {a > b, a == b, a < b});
            end
        end
        chk_outs("sweep", 6, 4, 6, 1, 2, 0, 0);
        chk("sweep.s_lt_cnt", 32'(s_lt_cnt), 32'd3);

        drive(0, 0, 3'b000);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
